present_sbox_layer_serializer: RTL and testbench
================================================

Name: present_sbox_layer_serializer

Overview:
- Nibble-serial driver for the PRESENT-80 masked S-box layer (GHPC, first order, 2 shares).
- Accepts a 64-bit two-share state. Feeds one nibble per cycle to the external pipelined masked S-box gadget and re-collects the substituted nibbles.
- Returns the 64-bit two-share S-box-layer result to the round datapath (pLayer/key addition downstream).
- Shares are never recombined inside the block.

Parameters:
- SBOX_LATENCY, 1, cycles from sbox_in* to matching sbox_out* of the attached masked S-box (legal 0..4).
- NIBBLES, 16, nibbles per state (fixed for PRESENT; not meant to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; samples state_in0/state_in1
- state_in0  in  64  share 0 of input state
- state_in1  in  64  share 1 of input state
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse; state_out* valid from this cycle
- state_out0  out  64  share 0 of S-box layer result (held until next done)
- state_out1  out  64  share 1 of S-box layer result
- sbox_in0  out  4  nibble share 0 to masked S-box
- sbox_in1  out  4  nibble share 1 to masked S-box
- sbox_out0  in  4  nibble share 0 from masked S-box
- sbox_out1  in  4  nibble share 1 from masked S-box

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, counters=0, busy=0, done=0, state_out*=0, sbox_in*=0, internal shift regs=0, valid pipe=0. Takes effect immediately, including mid-operation; the in-flight computation is discarded and no done is issued.
- FSM states: IDLE, FEED, DRAIN.
- IDLE: start=1 at edge E0 loads the in-shift regs (one per share, separate flops) and moves to FEED. start is ignored whenever busy=1.
- FEED: in cycle k (k=0..15, first cycle after E0), sbox_in* = nibble k of the loaded state, LSB nibble [3:0] first. The shift reg shifts right 4 each edge. The feed counter is 4-bit and wraps 15->0 on the transition to DRAIN.
- Outside FEED, sbox_in* = 0 to limit toggling of share wires.
- Valid pipe: SBOX_LATENCY-deep shift of the feed-valid bit. When the delayed valid is high, {sbox_out0, sbox_out1} shift into the out-shift regs at [63:60], shifting right 4. After 16 captures, nibble 0 sits at [3:0].
- With SBOX_LATENCY=0, capture occurs in the same cycle as feed. FSM goes FEED -> IDLE directly (no DRAIN); done is asserted the cycle after the 16th capture edge.
- DRAIN: waits for remaining captures; the capture counter reaching 16 ends it.
- Completion: on the 16th capture edge, the out-shift content is copied to state_out*. done=1 in the next cycle only; busy drops in that same cycle and FSM=IDLE.
- Total: start sampled at E0; done high in cycle 16+SBOX_LATENCY after E0.
- start coincident with done (FSM already IDLE) is accepted.
- Share-domain separation: no logic combines share 0 and share 1 signals. Muxes and registers are duplicated per share.
- The S-box randomness r is wired externally; this block does not gate it.

Decomposition:
- Shared package present_pkg holds: NIBBLES=16, STATE_W=64, NIB_W=4, FSM state enum (IDLE/FEED/DRAIN), and the PRESENT S-box constant table (used by the bench model only).
- One natural sub-module: present_nibble_shreg. It is a 64-bit load/shift-by-4 register with serial nibble in/out, instantiated once per share for the input side and once per share for the output side.

Test Plan:
- share0=0, share1=0, start, bench S-box model with L=1 -> done at cycle 17; state_out0^state_out1=64'hCCCCCCCCCCCCCCCC.
- share0=64'hFEDCBA9876543210 ^ M, share1=M (random M), L=2 -> done at cycle 18; unmasked result 64'h21748FE3DA09B65C.
- start pulsed again during FEED -> ignored; exactly one done; result unchanged from the first request.
- rst_n deasserted at feed cycle 7 -> outputs 0 immediately; no done; a subsequent start completes correctly.
- start asserted in the done cycle with a new state -> second run accepted; back-to-back done pulses 16+L cycles apart; both results correct.
- SBOX_LATENCY=0 and =4 builds -> done at cycles 16 and 20; sbox_in*=0 outside FEED; share 0 and share 1 never equal as a combined value on any internal net (assertion on netlist separation).

Source files
------------

// File: rtl/present_sbox_layer_serializer_pkg.sv
// present_pkg: shared widths, FSM encoding and the PRESENT S-box table (rev 1.0)
`default_nettype none

package present_pkg;

  localparam int NIBBLES = 16;
  localparam int STATE_W = 64;
  localparam int NIB_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Nibble x of this constant holds S(x).
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/present_nibble_shreg.sv
// present_nibble_shreg: load/shift-right-by-nibble register, one instance per share (rev 1.0)
`default_nettype none

module present_nibble_shreg
  import present_pkg::*;
#(
  parameter int WIDTH = STATE_W,
  parameter int NIB   = NIB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic [NIB-1:0]   nib_in,
  output logic [WIDTH-1:0] q,
  output logic [NIB-1:0]   nib_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {nib_in, q[WIDTH-1:NIB]};
    end
  end

  assign nib_out = q[NIB-1:0];

endmodule

`default_nettype wire

// File: rtl/present_sbox_layer_serializer.sv
// present_sbox_layer_serializer: nibble-serial driver for a 2-share masked PRESENT S-box (rev 1.0)
`default_nettype none

module present_sbox_layer_serializer
  import present_pkg::*;
#(
  parameter int SBOX_LATENCY = 1,
  parameter int NIBBLES      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [STATE_W-1:0]  state_in0,
  input  logic [STATE_W-1:0]  state_in1,
  output logic                busy,
  output logic                done,
  output logic [STATE_W-1:0]  state_out0,
  output logic [STATE_W-1:0]  state_out1,
  output logic [NIB_W-1:0]    sbox_in0,
  output logic [NIB_W-1:0]    sbox_in1,
  input  logic [NIB_W-1:0]    sbox_out0,
  input  logic [NIB_W-1:0]    sbox_out1
);

  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);

  state_t             state;
  logic [NIB_W-1:0]   feed_cnt;
  logic [NIB_W-1:0]   cap_cnt;
  logic               feed_valid;
  logic               cap_valid;
  logic               last_cap;
  logic               accept;
  logic [NIB_W-1:0]   in_nib0;
  logic [NIB_W-1:0]   in_nib1;
  logic [STATE_W-1:0] out_q0;
  logic [STATE_W-1:0] out_q1;
  logic [STATE_W-1:0] unused_q_in0;
  logic [STATE_W-1:0] unused_q_in1;
  logic [NIB_W-1:0]   unused_nib_out0;
  logic [NIB_W-1:0]   unused_nib_out1;

  assign feed_valid = (state == FEED);
  assign accept     = start && (state == IDLE);
  assign last_cap   = cap_valid && (cap_cnt == LAST_NIB);

  // Share wires stay quiet outside FEED; each share has its own mux.
  assign sbox_in0 = feed_valid ? in_nib0 : '0;
  assign sbox_in1 = feed_valid ? in_nib1 : '0;

  generate
    if (SBOX_LATENCY == 0) begin : g_no_lat
      assign cap_valid = feed_valid;
    end else begin : g_lat
      logic [SBOX_LATENCY-1:0] vpipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= feed_valid;
          for (int i = 1; i < SBOX_LATENCY; i++) begin
            vpipe[i] <= vpipe[i-1];
          end
        end
      end
      assign cap_valid = vpipe[SBOX_LATENCY-1];
    end
  endgenerate

  present_nibble_shreg u_in0 (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(state_in0),
    .shift(feed_valid), .nib_in('0), .q(unused_q_in0), .nib_out(in_nib0)
  );

  present_nibble_shreg u_in1 (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(state_in1),
    .shift(feed_valid), .nib_in('0), .q(unused_q_in1), .nib_out(in_nib1)
  );

  present_nibble_shreg u_out0 (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_data('0),
    .shift(cap_valid), .nib_in(sbox_out0), .q(out_q0), .nib_out(unused_nib_out0)
  );

  present_nibble_shreg u_out1 (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_data('0),
    .shift(cap_valid), .nib_in(sbox_out1), .q(out_q1), .nib_out(unused_nib_out1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      feed_cnt   <= '0;
      cap_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      state_out0 <= '0;
      state_out1 <= '0;
    end else begin
      done <= last_cap;
      if (cap_valid) begin
        cap_cnt <= cap_cnt + 1'b1;
      end
      // The final nibble is still on sbox_out*, so merge it while copying.
      if (last_cap) begin
        state_out0 <= {sbox_out0, out_q0[STATE_W-1:NIB_W]};
        state_out1 <= {sbox_out1, out_q1[STATE_W-1:NIB_W]};
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FEED;
            busy     <= 1'b1;
            feed_cnt <= '0;
          end
        end
        FEED: begin
          feed_cnt <= feed_cnt + 1'b1;
          if (last_cap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (feed_cnt == LAST_NIB) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_cap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_present_sbox_layer_serializer.sv
// tb_present_sbox_layer_serializer: scoreboard bench over four S-box latencies (0, 1, 2, 4)
`default_nettype none

module tb_present_sbox_layer_serializer;
  import present_pkg::*;

  localparam int NI = 4;
  localparam logic [63:0] EXP_B = 64'h0000FFFF0000FFFF;
  localparam logic [63:0] VAL_B = 64'h5555AAAA5555AAAA;

  typedef struct {
    logic [63:0] exp;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_g = 1'b0;
  logic [63:0] state_in0 = '0;
  logic [63:0] state_in1 = '0;
  logic        auto_arm = 1'b0;
  logic [63:0] exp_g = '0;
  int          base_g = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  event        push_ev;
  event        zero_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 0 : (gi == 1) ? 1 : (gi == 2) ? 2 : 4;
      logic        start;
      logic        busy;
      logic        done;
      logic [63:0] so0;
      logic [63:0] so1;
      logic [3:0]  si0;
      logic [3:0]  si1;
      logic [3:0]  sx0;
      logic [3:0]  sx1;
      logic [3:0]  f0;
      logic [3:0]  f1;
      logic [3:0]  d0 [4];
      logic [3:0]  d1 [4];
      logic        start_auto = 1'b0;
      logic        auto_used = 1'b0;
      exp_t        q [$];

      assign start = start_g | start_auto;

      present_sbox_layer_serializer #(.SBOX_LATENCY(L), .NIBBLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state_in0(state_in0), .state_in1(state_in1),
        .busy(busy), .done(done), .state_out0(so0), .state_out1(so1),
        .sbox_in0(si0), .sbox_in1(si1), .sbox_out0(sx0), .sbox_out1(sx1)
      );

      // Masked S-box model: share 1 carries the input mask through.
      assign f1 = si1;
      assign f0 = sbox(si0 ^ si1) ^ si1;
      always @(posedge clk) begin
        d0[0] <= f0;
        d1[0] <= f1;
        for (int i = 1; i < 4; i++) begin
          d0[i] <= d0[i-1];
          d1[i] <= d1[i-1];
        end
      end
      if (L == 0) begin : g_comb
        assign sx0 = f0;
        assign sx1 = f1;
      end else begin : g_dly
        assign sx0 = d0[L-1];
        assign sx1 = d1[L-1];
      end

      always @(push_ev) q.push_back('{exp_g, base_g + 16 + L});
      always @(negedge rst_n) q.delete();

      always @(zero_ev) begin
        checks++;
        if ({so0, so1, si0, si1, busy, done} != '0) begin
          failures++;
          $display("FAIL reset_zero lat=%0d got busy=%b done=%b out0=%h out1=%h in0=%h in1=%h want all zero",
                   L, busy, done, so0, so1, si0, si1);
        end
      end

      always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
          if (!busy) begin
            checks++;
            if (si0 != 4'h0 || si1 != 4'h0) begin
              failures++;
              $display("FAIL idle_sbox_in lat=%0d cyc=%0d got %h/%h want 0/0", L, cyc, si0, si1);
            end
          end
          if (done) begin
            if (q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_done lat=%0d cyc=%0d got done=1 want done=0", L, cyc);
            end else begin
              e = q.pop_front();
              checks++;
              if ((so0 ^ so1) != e.exp) begin
                failures++;
                $display("FAIL result lat=%0d got %h want %h", L, so0 ^ so1, e.exp);
              end
              checks++;
              if (cyc != e.due) begin
                failures++;
                $display("FAIL done_cycle lat=%0d got %0d want %0d", L, cyc, e.due);
              end
            end
          end else if (q.size() != 0 && cyc > q[0].due) begin
            checks++;
            failures++;
            $display("FAIL missing_done lat=%0d cyc=%0d got no done want done at %0d", L, cyc, q[0].due);
            void'(q.pop_front());
          end
        end
        if (rst_n && done && auto_arm && !auto_used) begin
          auto_used  = 1'b1;
          start_auto = 1'b1;
          q.push_back('{EXP_B, cyc + 1 + 16 + L});
        end else begin
          start_auto = 1'b0;
        end
      end
    end
  endgenerate

  function automatic int pending();
    return g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size() + g_dut[3].q.size();
  endfunction

  task automatic start_run(input logic [63:0] val, input logic [63:0] mask,
                           input logic [63:0] expv, input bit push);
    state_in0 = val ^ mask;
    state_in1 = mask;
    start_g   = 1'b1;
    if (push) begin
      exp_g  = expv;
      base_g = cyc + 1;
      ->push_ev;
    end
    @(negedge clk);
    start_g = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pending() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pending() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout got pending=%0d want 0", pending());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [63:0] m;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 ->zero_ev;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_run(64'h0, 64'h0, 64'hCCCCCCCCCCCCCCCC, 1);
    wait_idle();

    m = {$urandom, $urandom};
    start_run(64'hFEDCBA9876543210, m, 64'h21748FE3DA09B65C, 1);
    wait_idle();

    // Second start during FEED must be ignored.
    m = {$urandom, $urandom};
    start_run(64'h0123456789ABCDEF, m, 64'hC56B90AD3EF84712, 1);
    repeat (4) @(negedge clk);
    m = {$urandom, $urandom};
    start_run(64'hFFFFFFFFFFFFFFFF, m, 64'h0, 0);
    wait_idle();

    // Reset in feed cycle 7: run discarded, outputs cleared.
    m = {$urandom, $urandom};
    start_run(64'h1111111111111111, m, 64'h5555555555555555, 1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1 ->zero_ev;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    m = {$urandom, $urandom};
    start_run(64'hFEDCBA9876543210, m, 64'h21748FE3DA09B65C, 1);
    wait_idle();

    // Back-to-back: each instance restarts in its own done cycle.
    auto_arm = 1'b1;
    m = {$urandom, $urandom};
    start_run(64'hFFFFFFFF00000000, m, 64'h22222222CCCCCCCC, 1);
    m = {$urandom, $urandom};
    state_in0 = VAL_B ^ m;
    state_in1 = m;
    wait_idle();
    auto_arm = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
